// File: rtl/inst_queue.sv
// Decode-side instruction queue: circular FIFO taking up to IN_WIDTH fetch slots
// per cycle and presenting up to OUT_WIDTH oldest entries. Define INST_QUEUE_BYPASS_EN
// to let an empty queue forward the incoming bundle to decode in the same cycle.
module inst_queue #(
  parameter int DEPTH     = 16,
  parameter int IN_WIDTH  = 4,
  parameter int OUT_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [2:0]                in_count,
  input  logic [IN_WIDTH*32-1:0]    in_pc,
  input  logic [IN_WIDTH*32-1:0]    in_inst,
  input  logic [IN_WIDTH-1:0]       in_pred_taken,
  input  logic [IN_WIDTH*32-1:0]    in_pred_addr,
  output logic                      in_ready,
  output logic [OUT_WIDTH-1:0]      out_valid,
  output logic [OUT_WIDTH*32-1:0]   out_pc,
  output logic [OUT_WIDTH*32-1:0]   out_inst,
  output logic [OUT_WIDTH-1:0]      out_pred_taken,
  output logic [OUT_WIDTH*32-1:0]   out_pred_addr,
  input  logic [1:0]                out_take,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int DATA_W = 32;
  localparam int IW     = $clog2(DEPTH);
  localparam int PW     = IW + 1;

  logic [DATA_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] inst_mem  [DEPTH];
  logic [DATA_W-1:0] addr_mem  [DEPTH];
  logic              taken_mem [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] occ;
  logic [PW-1:0] free_slots;
  logic [2:0]    n_in;
  logic          enq;
  logic          bypass;
  logic [PW-1:0] avail;
  logic [PW-1:0] take_ext;
  logic [PW-1:0] deq_n;
  logic [IW-1:0] wr_idx [IN_WIDTH];
  logic [IW-1:0] rd_idx [OUT_WIDTH];

  // Occupancy from the wrap-extended pointers; full reads as exactly DEPTH.
  assign occ        = tail - head;
  assign count      = occ;
  assign free_slots = PW'(DEPTH) - occ;

  // Space check ignores this cycle's dequeue so in_ready never depends on out_take.
  assign in_ready = !rst && (free_slots >= PW'(IN_WIDTH));
  assign n_in     = (in_count > 3'(IN_WIDTH)) ? 3'(IN_WIDTH) : in_count;
  assign enq      = in_valid && in_ready && !flush;

  always_comb begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      wr_idx[i] = tail[IW-1:0] + IW'(i);
    end
    for (int i = 0; i < OUT_WIDTH; i++) begin
      rd_idx[i] = head[IW-1:0] + IW'(i);
    end
  end

  always_comb begin
    bypass = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
    bypass = enq && (occ == '0) && (n_in != 3'd0);
`endif
  end

  // Output slots: invalid slots are zeroed so decode never sees stale storage.
  always_comb begin
    out_valid      = '0;
    out_pc         = '0;
    out_inst       = '0;
    out_pred_taken = '0;
    out_pred_addr  = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      if (rst) begin
        out_valid[i] = 1'b0;
      end else if (bypass) begin
        if (3'(i) < n_in) begin
          out_valid[i]                = 1'b1;
          out_pc[DATA_W*i +: DATA_W]        = in_pc[DATA_W*i +: DATA_W];
          out_inst[DATA_W*i +: DATA_W]      = in_inst[DATA_W*i +: DATA_W];
          out_pred_taken[i]                 = in_pred_taken[i];
          out_pred_addr[DATA_W*i +: DATA_W] = in_pred_addr[DATA_W*i +: DATA_W];
        end
      end else if (occ > PW'(i)) begin
        out_valid[i]                      = 1'b1;
        out_pc[DATA_W*i +: DATA_W]        = pc_mem[rd_idx[i]];
        out_inst[DATA_W*i +: DATA_W]      = inst_mem[rd_idx[i]];
        out_pred_taken[i]                 = taken_mem[rd_idx[i]];
        out_pred_addr[DATA_W*i +: DATA_W] = addr_mem[rd_idx[i]];
      end
    end
  end

  always_comb begin
    avail = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      if (out_valid[i]) begin
        avail = avail + PW'(1);
      end
    end
  end

  // Excess out_take is clipped to what is actually presented.
  assign take_ext = PW'(out_take);
  assign deq_n    = (take_ext < avail) ? take_ext : avail;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head + deq_n;
      if (enq) begin
        tail <= tail + PW'(n_in);
      end
    end
  end

  // Storage is data-only: never reset, written only for the leading n slots.
  always_ff @(posedge clk) begin
    if (enq) begin
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (3'(i) < n_in) begin
          pc_mem[wr_idx[i]]    <= in_pc[DATA_W*i +: DATA_W];
          inst_mem[wr_idx[i]]  <= in_inst[DATA_W*i +: DATA_W];
          taken_mem[wr_idx[i]] <= in_pred_taken[i];
          addr_mem[wr_idx[i]]  <= in_pred_addr[DATA_W*i +: DATA_W];
        end
      end
    end
  end

endmodule
